// File: rtl/ifu_prefetch.sv
// Autonomous sequential instruction prefetcher: pipelined AXI-lite reads feeding
// an instruction queue, with redirect-driven flush and stale-response discard.
module ifu_prefetch #(
    parameter int          ADDR_W          = 32,
    parameter int          DATA_W          = 32,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    output logic [2:0]        arsize,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    localparam int STEP   = DATA_W / 8;
    localparam int QPTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = QPTR_W + 1;
    localparam int INF_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int TPTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [INF_W-1:0]  inflight;
    logic [INF_W-1:0]  discard;

    logic [DATA_W-1:0]     q_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]     q_pc   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] q_fault;
    logic [QPTR_W-1:0]     q_head;
    logic [QPTR_W-1:0]     q_tail;
    logic [CNT_W-1:0]      count;

    logic [ADDR_W-1:0] tag_pc [MAX_OUTSTANDING];
    logic [TPTR_W-1:0] tag_head;
    logic [TPTR_W-1:0] tag_tail;

    logic        r_hs;
    logic        issue;
    logic        push;
    logic        pop;
    logic [31:0] credit_used;

    assign arsize = 3'($clog2(STEP));
    assign rready = 1'b1;

    // Credit counts in-flight reads against free queue slots, so every response is guaranteed a home.
    assign r_hs        = rvalid;
    assign credit_used = 32'(count) + 32'(inflight);
    assign issue       = (!arvalid || arready) && !redirect_valid
                         && (32'(inflight) < 32'(MAX_OUTSTANDING))
                         && (credit_used < 32'(FIFO_DEPTH));
    assign push        = r_hs && (discard == '0) && !redirect_valid;
    assign pop         = inst_valid && inst_ready;

    function automatic logic [TPTR_W-1:0] tag_next(input logic [TPTR_W-1:0] p);
        return (p == TPTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + TPTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            arvalid  <= 1'b0;
            araddr   <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            tag_head <= '0;
            tag_tail <= '0;
        end else begin
            if (issue) begin
                arvalid  <= 1'b1;
                araddr   <= fetch_pc;
                tag_tail <= tag_next(tag_tail);
            end else if (arvalid && arready) begin
                arvalid <= 1'b0;
            end

            if (redirect_valid)
                fetch_pc <= redirect_pc & ~ADDR_W'(STEP - 1);
            else if (issue)
                fetch_pc <= fetch_pc + ADDR_W'(STEP);

            if (r_hs)
                tag_head <= tag_next(tag_head);

            inflight <= inflight + INF_W'(issue) - INF_W'(r_hs);

            // Everything still outstanding after a redirect belongs to the old stream.
            if (redirect_valid)
                discard <= inflight - INF_W'(r_hs);
            else if (r_hs && discard != '0)
                discard <= discard - INF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (issue)
            tag_pc[tag_tail] <= fetch_pc;
        if (push) begin
            q_data[q_tail]  <= rdata;
            q_pc[q_tail]    <= tag_pc[tag_head];
            q_fault[q_tail] <= |rresp;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_head <= '0;
            q_tail <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            q_head <= '0;
            q_tail <= '0;
            count  <= '0;
        end else begin
            if (push)
                q_tail <= q_tail + QPTR_W'(1);
            if (pop)
                q_head <= q_head + QPTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? q_data[q_head]  : '0;
    assign inst_pc    = inst_valid ? q_pc[q_head]    : '0;
    assign inst_fault = inst_valid ? q_fault[q_head] : 1'b0;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with a 1-cycle-latency AXI-lite read responder.
module tb_ifu_prefetch;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b1;
    logic [2:0]  arsize;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;

    logic [31:0] fault_addr = 32'h1;
    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;

    logic [31:0] ar_log[$];
    int          ar_cyc[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_data[$];
    logic        pop_fault[$];

    ifu_prefetch #(
        .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2),
        .RESET_PC(32'h8000_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_fault(inst_fault),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arsize(arsize),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    // Read responder plus logging of AR handshakes and consumed instructions.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= '0;
        end else begin
            cycle++;
            if (arvalid && arready) begin
                ar_log.push_back(araddr);
                ar_cyc.push_back(cycle);
            end
            if (inst_valid && inst_ready) begin
                pop_pc.push_back(inst_pc);
                pop_data.push_back(inst);
                pop_fault.push_back(inst_fault);
            end
            rvalid <= arvalid && arready;
            rdata  <= araddr ^ KEY;
            rresp  <= (araddr == fault_addr) ? 2'b10 : 2'b00;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic arrdy);
        inst_ready = rdy;
        arready    = arrdy;
    endtask

    task automatic doReset(input logic rdy, input logic arrdy);
        @(negedge clk);
        rst = 1'b0;
        redirect_valid = 1'b0;
        applyStimulus(rdy, arrdy);
        repeat (2) @(negedge clk);
        ar_log.delete();
        ar_cyc.delete();
        pop_pc.delete();
        pop_data.delete();
        pop_fault.delete();
        rst = 1'b1;
    endtask

    task automatic doRedirect(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic waitPops(input int n);
        int budget = 60;
        while (pop_pc.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("pop_count", 64'(pop_pc.size()), 64'(n));
    endtask

    task automatic checkPops(input string tag, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_pc"},   64'(pop_pc[i]),   64'(base + 32'(4 * i)));
            checkOutput({tag, "_data"}, 64'(pop_data[i]), 64'((base + 32'(4 * i)) ^ KEY));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_arvalid"},    64'(arvalid),    64'(0));
        checkOutput({tag, "_araddr"},     64'(araddr),     64'(32'h8000_0000));
        checkOutput({tag, "_inst_valid"}, 64'(inst_valid), 64'(0));
        checkOutput({tag, "_inst"},       64'(inst),       64'(0));
        checkOutput({tag, "_inst_pc"},    64'(inst_pc),    64'(0));
        checkOutput({tag, "_inst_fault"}, 64'(inst_fault), 64'(0));
    endtask

    initial begin
        // Reset values, then a free-running sequential stream.
        #1 rst = 1'b0;
        #1 checkResetOutputs("rst");
        checkOutput("arsize", 64'(arsize), 64'(2));
        checkOutput("rready", 64'(rready), 64'(1));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        waitPops(4);
        checkPops("seq", 32'h8000_0000, 4);
        for (int i = 0; i < 4; i++)
            checkOutput("seq_fault", 64'(pop_fault[i]), 64'(0));
        checkOutput("seq_b2b_ar", 64'(ar_cyc[1] - ar_cyc[0]), 64'(1));
        checkOutput("seq_ar2", 64'(ar_log[2]), 64'(32'h8000_0008));

        // Stalled consumer fills the queue, then a single pop frees one credit.
        doReset(1'b0, 1'b1);
        repeat (30) @(negedge clk);
        checkOutput("full_ar_count", 64'(ar_log.size()), 64'(4));
        checkOutput("full_arvalid", 64'(arvalid), 64'(0));
        checkOutput("full_head_pc", 64'(inst_pc), 64'(32'h8000_0000));
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("refill_ar_count", 64'(ar_log.size()), 64'(5));
        checkOutput("refill_ar_addr", 64'(ar_log[4]), 64'(32'h8000_0010));
        checkOutput("refill_head_pc", 64'(inst_pc), 64'(32'h8000_0004));

        // Redirect with two reads outstanding; unaligned target gets aligned.
        doReset(1'b1, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("redir_pre_araddr", 64'({arvalid, araddr}), 64'({1'b1, 32'h8000_0004}));
        doRedirect(32'h8000_0103);
        waitPops(3);
        checkPops("redir", 32'h8000_0100, 3);

        // Redirect while an AR is stuck waiting for arready.
        doReset(1'b1, 1'b0);
        @(negedge clk);
        doRedirect(32'h8000_0200);
        checkOutput("hold1", 64'({arvalid, araddr}), 64'({1'b1, 32'h8000_0000}));
        @(negedge clk);
        checkOutput("hold2", 64'({arvalid, araddr}), 64'({1'b1, 32'h8000_0000}));
        @(negedge clk);
        checkOutput("hold3", 64'({arvalid, araddr}), 64'({1'b1, 32'h8000_0000}));
        applyStimulus(1'b1, 1'b1);
        waitPops(2);
        checkOutput("hold_ar0", 64'(ar_log[0]), 64'(32'h8000_0000));
        checkOutput("hold_ar1", 64'(ar_log[1]), 64'(32'h8000_0200));
        checkPops("hold", 32'h8000_0200, 2);

        // Error response on the second read only.
        fault_addr = 32'h8000_0004;
        doReset(1'b1, 1'b1);
        waitPops(3);
        checkPops("fault", 32'h8000_0000, 3);
        checkOutput("fault0", 64'(pop_fault[0]), 64'(0));
        checkOutput("fault1", 64'(pop_fault[1]), 64'(1));
        checkOutput("fault2", 64'(pop_fault[2]), 64'(0));
        fault_addr = 32'h1;

        // Wrap at the top of the address space, then asynchronous reset mid-burst.
        doReset(1'b1, 1'b1);
        @(negedge clk);
        doRedirect(32'hFFFF_FFF8);
        waitPops(3);
        checkOutput("wrap_pc0", 64'(pop_pc[0]), 64'(32'hFFFF_FFF8));
        checkOutput("wrap_pc1", 64'(pop_pc[1]), 64'(32'hFFFF_FFFC));
        checkOutput("wrap_pc2", 64'(pop_pc[2]), 64'(32'h0000_0000));
        checkOutput("wrap_data2", 64'(pop_data[2]), 64'(32'h0000_0000 ^ KEY));
        @(posedge clk);
        #2 rst = 1'b0;
        #1 checkResetOutputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
